// File: rtl/request_arbiter.sv
// Round-robin arbiter sharing one AXIS row-request channel between host, button and timer requesters.
// Define REQ_DROP_COUNT_EN to add a saturating DROP_COUNT output counting coalesced-away requests.
module request_arbiter #(
  parameter int DW             = 256,
  parameter int ROWS_PER_FRAME = 8,
  parameter int FIRST_FRAME    = 12,
  parameter int TIMER_PERIOD   = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          BUTTON,
  input  logic          AUTO_EN,
  input  logic          HOST_REQ,
  input  logic [15:0]   HOST_FRAME,
  output logic [DW-1:0] AXIS_TX_TDATA,
  output logic          AXIS_TX_TVALID,
  output logic          AXIS_TX_TLAST,
  input  logic          AXIS_TX_TREADY,
`ifdef REQ_DROP_COUNT_EN
  output logic [15:0]   DROP_COUNT,
`endif
  output logic          BUSY
);

  localparam int            TW         = $clog2(TIMER_PERIOD);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMER_PERIOD - 1);
  localparam logic [7:0]    LAST_ROW   = 8'(ROWS_PER_FRAME - 1);
  localparam logic [1:0]    SRC_HOST   = 2'd0;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_next;
  logic [2:0]    pend, pend_next;
  logic [15:0]   host_frame, host_frame_next;
  logic          btn_prev;
  logic [TW-1:0] timer, timer_next;
  logic [15:0]   auto_frame, auto_frame_next;
  logic [1:0]    rr_ptr, rr_next;
  logic [7:0]    row, row_next;
  logic [1:0]    src, src_next;
  logic [15:0]   frame, frame_next;
  logic          tvalid, tvalid_next;
  logic          tlast, tlast_next;
  logic [2:0]    events, clear, drops;
  logic [1:0]    grant;
  logic          grant_valid;

  // Pending bits are indexed by source code: 0 host, 1 button, 2 timer.
  always_comb begin
    grant_valid = |pend;
    grant       = 2'd0;
    case (rr_ptr)
      2'd0:    grant = pend[1] ? 2'd1 : (pend[2] ? 2'd2 : 2'd0);
      2'd1:    grant = pend[2] ? 2'd2 : (pend[0] ? 2'd0 : 2'd1);
      default: grant = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    events          = {AUTO_EN && (timer == TIMER_LAST), BUTTON & ~btn_prev, HOST_REQ};
    clear           = (state == IDLE && grant_valid) ? (3'b001 << grant) : 3'b000;
    drops           = events & pend & ~clear;
    pend_next       = events | (pend & ~clear);
    host_frame_next = (HOST_REQ && !drops[0]) ? HOST_FRAME : host_frame;
    timer_next      = '0;
    if (AUTO_EN && timer != TIMER_LAST) begin
      timer_next = timer + TW'(1);
    end
  end

  always_comb begin
    state_next      = state;
    rr_next         = rr_ptr;
    row_next        = row;
    src_next        = src;
    frame_next      = frame;
    tvalid_next     = tvalid;
    tlast_next      = tlast;
    auto_frame_next = auto_frame;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next  = SEND;
          rr_next     = grant;
          row_next    = 8'd0;
          src_next    = grant;
          frame_next  = (grant == SRC_HOST) ? host_frame : auto_frame;
          tvalid_next = 1'b1;
          tlast_next  = (LAST_ROW == 8'd0);
        end
      end
      SEND: begin
        if (tvalid && AXIS_TX_TREADY) begin
          if (tlast) begin
            state_next  = IDLE;
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
            // Only auto-sourced bursts advance the shared frame counter.
            if (src != SRC_HOST) begin
              auto_frame_next = auto_frame + 16'd1;
            end
          end else begin
            row_next   = row + 8'd1;
            tlast_next = (row + 8'd1 == LAST_ROW);
          end
        end
      end
      default: ;
    endcase
  end

  // Loading btn_prev from BUTTON on reset suppresses a request for a level held through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend       <= '0;
      host_frame <= '0;
      btn_prev   <= BUTTON;
      timer      <= '0;
      auto_frame <= 16'(FIRST_FRAME);
      rr_ptr     <= 2'd2;
      row        <= '0;
      src        <= '0;
      frame      <= '0;
      tvalid     <= 1'b0;
      tlast      <= 1'b0;
    end else begin
      state      <= state_next;
      pend       <= pend_next;
      host_frame <= host_frame_next;
      btn_prev   <= BUTTON;
      timer      <= timer_next;
      auto_frame <= auto_frame_next;
      rr_ptr     <= rr_next;
      row        <= row_next;
      src        <= src_next;
      frame      <= frame_next;
      tvalid     <= tvalid_next;
      tlast      <= tlast_next;
    end
  end

`ifdef REQ_DROP_COUNT_EN
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, DROP_COUNT} + 17'(drops[0]) + 17'(drops[1]) + 17'(drops[2]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      DROP_COUNT <= '0;
    end else begin
      DROP_COUNT <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`else
  logic unused_drops;
  assign unused_drops = ^drops;
`endif

  always_comb begin
    AXIS_TX_TDATA       = '0;
    AXIS_TX_TDATA[31:0] = {frame, 6'd0, src, row};
  end

  assign AXIS_TX_TVALID = tvalid;
  assign AXIS_TX_TLAST  = tlast;
  assign BUSY           = (state == SEND);

endmodule

// File: tb/tb_request_arbiter.sv
// Bench for request_arbiter: table vectors, directed corner sequences and a randomized run
// compared cycle by cycle against a behavioural model of the arbitration rules.
`timescale 1ns/1ps
module tb_request_arbiter;

  localparam int R  = 8;
  localparam int FF = 12;
  localparam int TP = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, button, auto_en, host_req, tready;
  logic [15:0]  host_frame;
  logic [255:0] tdata;
  logic         tvalid, tlast, busy;
  logic         b_reset, b_button, b_tready;
  logic [255:0] b_tdata;
  logic         b_tvalid, b_tlast, b_busy;
`ifdef REQ_DROP_COUNT_EN
  logic [15:0]  drop_count, b_drop_count;
`endif

  request_arbiter #(.DW(256), .ROWS_PER_FRAME(R), .FIRST_FRAME(FF), .TIMER_PERIOD(TP)) dut (
    .clk(clk), .reset(reset), .BUTTON(button), .AUTO_EN(auto_en), .HOST_REQ(host_req),
    .HOST_FRAME(host_frame), .AXIS_TX_TDATA(tdata), .AXIS_TX_TVALID(tvalid),
    .AXIS_TX_TLAST(tlast), .AXIS_TX_TREADY(tready),
`ifdef REQ_DROP_COUNT_EN
    .DROP_COUNT(drop_count),
`endif
    .BUSY(busy));

  request_arbiter #(.DW(256), .ROWS_PER_FRAME(1), .FIRST_FRAME(16'hFFFF), .TIMER_PERIOD(5)) dut_b (
    .clk(clk), .reset(b_reset), .BUTTON(b_button), .AUTO_EN(1'b0), .HOST_REQ(1'b0),
    .HOST_FRAME(16'h0000), .AXIS_TX_TDATA(b_tdata), .AXIS_TX_TVALID(b_tvalid),
    .AXIS_TX_TLAST(b_tlast), .AXIS_TX_TREADY(b_tready),
`ifdef REQ_DROP_COUNT_EN
    .DROP_COUNT(b_drop_count),
`endif
    .BUSY(b_busy));

  int n_compared = 0;
  int n_failed   = 0;

  typedef struct {
    bit btn;
    bit rdy;
    bit exp_valid;
    bit exp_last;
    int exp_row;
    int exp_frame;
  } vec_t;
  vec_t vecs[15];

  // Behavioural model state: pending set, round-robin pointer, and the burst in flight.
  bit m_pend[3];
  bit m_prev_btn, m_active;
  int m_hframe, m_timer, m_auto, m_rr, m_src, m_frame, m_row, m_drops;

  int n, s, f, cnt;
  bit ok, reached;
  int exp_src[6] = '{0, 0, 0, 2, 0, 2};
  int exp_frm[6] = '{16'h0ABC, 16'h0ABC, 16'h0ABC, 12, 16'h0ABC, 13};

  function automatic logic [255:0] beatWord(input int frame, input int src, input int row);
    logic [255:0] w;
    w = '0;
    w[31:16] = 16'(frame);
    w[9:8]   = 2'(src);
    w[7:0]   = 8'(row);
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelStep();
    bit ev[3];
    int g, c;
    if (reset) begin
      for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
      m_prev_btn = button;
      m_active = 1'b0;
      m_timer = 0;
      m_auto = FF;
      m_rr = 2;
      m_drops = 0;
      return;
    end
    ev[0] = host_req;
    ev[1] = button && !m_prev_btn;
    ev[2] = auto_en && (m_timer == TP - 1);
    m_timer = auto_en ? (m_timer + 1) % TP : 0;
    m_prev_btn = button;
    g = -1;
    if (!m_active) begin
      for (int k = 1; k <= 3; k++) begin
        c = (m_rr + k) % 3;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (m_active) begin
      if (tready) begin
        if (m_row == R - 1) begin
          m_active = 1'b0;
          if (m_src != 0) m_auto = (m_auto + 1) % 65536;
        end else begin
          m_row++;
        end
      end
    end else if (g >= 0) begin
      m_pend[g] = 1'b0;
      m_rr = g;
      m_active = 1'b1;
      m_src = g;
      m_row = 0;
      m_frame = (g == 0) ? m_hframe : m_auto;
    end
    for (int i = 0; i < 3; i++) begin
      if (ev[i]) begin
        if (m_pend[i]) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          m_pend[i] = 1'b1;
          if (i == 0) m_hframe = int'(host_frame);
        end
      end
    end
  endtask

  task automatic compareModel();
    checkOutput("model_tvalid", tvalid, m_active);
    checkOutput("model_tlast", tlast, m_active && (m_row == R - 1));
    checkOutput("model_busy", busy, m_active);
    if (m_active) checkOutput("model_tdata", tdata, beatWord(m_frame, m_src, m_row));
`ifdef REQ_DROP_COUNT_EN
    checkOutput("model_drop_count", drop_count, 16'(m_drops));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    compareModel();
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    checkOutput("rst_tvalid", tvalid, 1'b0);
    checkOutput("rst_tlast", tlast, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_tdata", tdata, '0);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    button   = v.btn;
    tready   = v.rdy;
    host_req = 1'b0;
    tick();
  endtask

  // Collects one complete burst; ok stays set only if rows are contiguous, TLAST sits on the
  // final row, source/frame are constant and the burst completes within the budget.
  task automatic collectBurst(input logic [3:0] pattern, input int budget,
                              output int nb, output int bsrc, output int bframe, output bit bok);
    bit done;
    nb = 0; bsrc = -1; bframe = -1; bok = 1'b1; done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tready = pattern[2'(c % 4)];
      if (tvalid && tready) begin
        if (nb == 0) begin
          bsrc   = int'(tdata[9:8]);
          bframe = int'(tdata[31:16]);
        end
        if (int'(tdata[7:0]) != nb || int'(tdata[9:8]) != bsrc ||
            int'(tdata[31:16]) != bframe || tlast != (nb == R - 1)) bok = 1'b0;
        nb++;
        done = tlast;
      end
      tick();
    end
    tready = 1'b1;
    if (!done) bok = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; button = 1'b0; auto_en = 1'b0; host_req = 1'b0; tready = 1'b1;
    host_frame = 16'h0000;
    b_reset = 1'b1; b_button = 1'b0; b_tready = 1'b1;

    for (int i = 0; i < 15; i++)
      vecs[i] = '{btn: 1'b1, rdy: 1'b1, exp_valid: 1'b0, exp_last: 1'b0, exp_row: 0, exp_frame: 12};
    for (int i = 1; i <= 8; i++) begin
      vecs[i].exp_valid = 1'b1;
      vecs[i].exp_row   = i - 1;
    end
    vecs[8].exp_last   = 1'b1;
    vecs[11].btn       = 1'b0;
    vecs[13].exp_valid = 1'b1;
    vecs[13].exp_frame = 13;
    vecs[14].exp_valid = 1'b1;
    vecs[14].exp_row   = 1;
    vecs[14].exp_frame = 13;

    $display("[TB] table: button press bursts");
    doReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_tvalid", i), tvalid, vecs[i].exp_valid);
      checkOutput($sformatf("vec%0d_tlast", i), tlast, vecs[i].exp_last);
      if (vecs[i].exp_valid)
        checkOutput($sformatf("vec%0d_tdata", i), tdata, beatWord(vecs[i].exp_frame, 1, vecs[i].exp_row));
    end
    for (int i = 0; i < 8; i++) tick();
    button = 1'b0;
    tick();

    $display("[TB] host and button on the same cycle");
    doReset();
    host_req = 1'b1; host_frame = 16'h0100; button = 1'b1;
    tick();
    host_req = 1'b0;
    collectBurst(4'hF, 40, n, s, f, ok);
    checkOutput("hb_first_beats", n, R);
    checkOutput("hb_first_src", s, 0);
    checkOutput("hb_first_frame", f, 16'h0100);
    checkOutput("hb_first_ok", ok, 1'b1);
    collectBurst(4'hF, 40, n, s, f, ok);
    checkOutput("hb_second_src", s, 1);
    checkOutput("hb_second_frame", f, 12);
    checkOutput("hb_second_ok", ok, 1'b1);
    button = 1'b0; tick(); button = 1'b1;
    collectBurst(4'hF, 40, n, s, f, ok);
    checkOutput("hb_third_frame", f, 13);
    checkOutput("hb_third_ok", ok, 1'b1);
    button = 1'b0;

    $display("[TB] TREADY stalls during a burst");
    doReset();
    button = 1'b1;
    collectBurst(4'b1001, 80, n, s, f, ok);
    checkOutput("stall_beats", n, R);
    checkOutput("stall_frame", f, 12);
    checkOutput("stall_ok", ok, 1'b1);
    button = 1'b0;

    $display("[TB] repeated host strobes during a burst");
    doReset();
    button = 1'b1; tready = 1'b0;
    tick(); tick();
    host_req = 1'b1; host_frame = 16'h1111; tick();
    host_frame = 16'h2222; tick();
    host_frame = 16'h3333; tick();
    host_req = 1'b0;
`ifdef REQ_DROP_COUNT_EN
    checkOutput("strobe_drop_count", drop_count, 16'd2);
`endif
    collectBurst(4'hF, 40, n, s, f, ok);
    checkOutput("strobe_btn_src", s, 1);
    checkOutput("strobe_btn_ok", ok, 1'b1);
    collectBurst(4'hF, 40, n, s, f, ok);
    checkOutput("strobe_host_src", s, 0);
    checkOutput("strobe_host_frame", f, 16'h1111);
    checkOutput("strobe_host_ok", ok, 1'b1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tvalid) cnt++;
    end
    checkOutput("strobe_no_extra_burst", cnt, 0);
    button = 1'b0;

    $display("[TB] timer and host alternation");
    auto_en = 1'b1; host_frame = 16'h0ABC;
    doReset();
    host_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      collectBurst(4'hF, 40, n, s, f, ok);
      checkOutput($sformatf("alt%0d_src", i), s, exp_src[i]);
      checkOutput($sformatf("alt%0d_frame", i), f, exp_frm[i]);
      checkOutput($sformatf("alt%0d_ok", i), ok, 1'b1);
    end
    host_req = 1'b0; auto_en = 1'b0;

    $display("[TB] reset in the middle of a burst");
    doReset();
    button = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      tick();
      if (tvalid && tdata[7:0] == 8'd3) reached = 1'b1;
    end
    checkOutput("midrst_reached_row3", reached, 1'b1);
    doReset();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tvalid) cnt++;
    end
    checkOutput("midrst_no_beats", cnt, 0);
    button = 1'b0; tick(); button = 1'b1;
    collectBurst(4'hF, 40, n, s, f, ok);
    checkOutput("midrst_frame", f, 12);
    checkOutput("midrst_ok", ok, 1'b1);
    button = 1'b0;

    $display("[TB] single-row bursts and frame wrap");
    b_reset = 1'b1; tick(); b_reset = 1'b0;
    checkOutput("b_rst_tvalid", b_tvalid, 1'b0);
    b_button = 1'b1; tick(); tick();
    checkOutput("b_first_tvalid", b_tvalid, 1'b1);
    checkOutput("b_first_tlast", b_tlast, 1'b1);
    checkOutput("b_first_tdata", b_tdata, beatWord(16'hFFFF, 1, 0));
    tick();
    checkOutput("b_first_done", b_tvalid, 1'b0);
    b_button = 1'b0; tick(); b_button = 1'b1; tick(); tick();
    checkOutput("b_wrap_tvalid", b_tvalid, 1'b1);
    checkOutput("b_wrap_tlast", b_tlast, 1'b1);
    checkOutput("b_wrap_tdata", b_tdata, beatWord(0, 1, 0));
    b_button = 1'b0;

    $display("[TB] randomized run against the model");
    doReset();
    for (int i = 0; i < 4000; i++) begin
      host_req   = ($urandom_range(0, 7) == 0);
      host_frame = 16'($urandom);
      if ($urandom_range(0, 15) == 0) button = ~button;
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      tready = ($urandom_range(0, 3) != 0);
      reset  = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/request_arbiter.md
Name: request_arbiter

Overview:
- Shares the single AXIS row-request channel between three requesters: host command, front-panel BUTTON and an internal periodic timer.
- Each granted request becomes one burst of ROWS_PER_FRAME row-request beats for one frame.
- Sits between the control inputs and the request consumer, replacing direct button-driven request generation.
- Round-robin arbitration between requesters; pending requests are coalesced (at most one pending per requester).

Parameters:
- DW, 256, AXIS TDATA width (bits above 31 are driven 0).
- ROWS_PER_FRAME, 8, beats per burst; legal range 1..256.
- FIRST_FRAME, 12, reset value of the auto frame counter.
- TIMER_PERIOD, 1000000, clocks between timer requests while AUTO_EN=1; legal range >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- BUTTON  in  1  level input; each rising edge is one request.
- AUTO_EN  in  1  enables the periodic timer requester.
- HOST_REQ  in  1  one-cycle strobe; one request per high cycle.
- HOST_FRAME  in  16  frame number for a host request, sampled with HOST_REQ.
- AXIS_TX_TDATA  out  DW  request beat: [7:0] row, [9:8] source (0 host, 1 button, 2 timer), [15:10] 0, [31:16] frame.
- AXIS_TX_TVALID  out  1  beat valid.
- AXIS_TX_TLAST  out  1  last beat of burst.
- AXIS_TX_TREADY  in  1  consumer ready.
- BUSY  out  1  high whenever state is SEND.

Behaviour:
- Reset (has priority over everything):
  - TVALID, TLAST, BUSY = 0; TDATA = 0.
  - All pending flags cleared; timer = 0; auto frame = FIRST_FRAME; RR pointer = 2, so host wins first.
  - BUTTON edge register loaded with the current BUTTON value, so a level held high through reset does not generate a request.
  - Reset mid-burst drops TVALID at that edge; the burst is abandoned and never resumed.
- Request capture, on the edge where the event is sampled:
  - Host: HOST_REQ=1 sets host_pend and latches HOST_FRAME.
  - Button: BUTTON=1 with the previous sample 0 sets btn_pend.
  - Timer: when AUTO_EN=1 and the timer reaches TIMER_PERIOD-1, timer returns to 0 and tmr_pend is set.
  - AUTO_EN=0 holds the timer at 0; an existing tmr_pend is still served.
  - An event for a requester that is already pending is dropped. A dropped host request does not overwrite the latched frame.
- FSM, two states:
  - IDLE: if any pending flag is set, grant the first pending requester searching RR pointer+1, +2, +3 (mod 3). On that edge: clear its pending flag, RR pointer = grant, row = 0, frame = host latched frame (host) or auto frame (button/timer), TVALID = 1, TLAST = (ROWS_PER_FRAME==1), state = SEND.
  - Latency: TVALID is high on the cycle after the pending flag becomes visible, i.e. 2 clocks after the strobe is sampled.
  - SEND: TDATA, TVALID and TLAST are held stable while TVALID & !TREADY.
    - On TVALID & TREADY when it is not the last beat: row += 1; TLAST = (row+1 == ROWS_PER_FRAME-1).
    - On TVALID & TREADY on the last beat: TVALID = 0, TLAST = 0, state = IDLE. If the source was button or timer, auto frame += 1, wrapping 0xFFFF -> 0x0000.
- Boundary cases:
  - At least one idle cycle between bursts.
  - An event for the granted requester on the grant edge sets its flag again: set wins over clear.
  - Events during SEND are captured normally.
  - Host requests never change the auto frame counter.

Optional Feature:
- Macro: REQ_DROP_COUNT_EN.
- Defined: adds output DROP_COUNT [15:0], reset 0, incremented by the number of requests dropped on each edge (0..3, one per requester that drops). Saturates at 0xFFFF.
- Not defined: the port does not exist; dropped requests are silently discarded. All other behaviour is identical.

Test Plan:
- Reset, then BUTTON 0->1 held high, TREADY=1:
  - TVALID rises 2 clocks after the edge is sampled.
  - 8 beats: rows 0..7, source 1, frame 12; TLAST only on row 7; no second burst while BUTTON stays high.
  - A second press gives frame 13.
- HOST_REQ with HOST_FRAME=0x0100 and a BUTTON edge on the same cycle after reset:
  - Host burst first (source 0, frame 0x0100), then button burst (source 1, frame 12).
  - Auto frame is 13 afterwards.
- TREADY toggled 1-0-0-1 during a burst: TDATA and TLAST are held while TREADY=0; rows stay contiguous 0..7; no beat is lost or duplicated.
- TIMER_PERIOD=20, AUTO_EN=1, three HOST_REQ strobes 1 cycle apart during a burst:
  - Host served once; two requests dropped (DROP_COUNT=2 with REQ_DROP_COUNT_EN).
  - Timer and host grants alternate while both stay pending.
- Reset asserted on beat 3 of a burst: TVALID=0 on the next cycle, no further beats, and the next button burst uses frame 12.
- ROWS_PER_FRAME=1, auto frame forced to 0xFFFF: single beat with TLAST=1, frame 0xFFFF; the next auto burst uses frame 0x0000.
